// File: rtl/m_dm_load_ctrl_pkg.sv
// Shared definitions for the M-stage load engine.
//   - load op codes (same numbering as the store op codes)
//   - load engine state encoding
//   - AdEL exception code
//   - address-error predicate for a load op/address pair
package m_dm_load_ctrl_pkg;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_H  = 3'd1,
    LD_HU = 3'd2,
    LD_B  = 3'd3,
    LD_BU = 3'd4
  } ld_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } ld_state_e;

  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Op codes above LD_BU are treated like a misaligned access (AdEL).
  function automatic logic ld_adel(input logic [2:0] op, input logic [1:0] a);
    ld_adel = ((op == LD_W) && (a != 2'b00)) ||
              (((op == LD_H) || (op == LD_HU)) && a[0]) ||
              (op > LD_BU);
  endfunction

endpackage

// File: rtl/m_dm_load_ctrl_ext.sv
// m_load_ext: combinational load-data extraction.
// Selects the byte/half/word addressed by a[1:0] out of the bus word and
// sign- or zero-extends it according to op.
//   op    in  3   load op code (ld_op_e)
//   a     in  2   byte offset within the word
//   word  in  32  word read from the bus
//   data  out 32  extended load result (0 for illegal ops)
module m_load_ext
  import m_dm_load_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  a,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  always_comb begin
    half   = a[1] ? word[31:16] : word[15:0];
    byte_v = word[7:0];
    case (a)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase

    data = '0;
    case (op)
      LD_W:    data = word;
      LD_H:    data = {{16{half[15]}}, half};
      LD_HU:   data = {16'h0000, half};
      LD_B:    data = {{24{byte_v[7]}}, byte_v};
      LD_BU:   data = {24'h000000, byte_v};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/m_dm_load_ctrl.sv
// m_dm_load_ctrl: M-stage load engine.
// Accepts a load from the M stage, runs one word-aligned req/ack read on the
// data bus, extracts/extends the result, and stalls the pipeline while busy.
// Flags AdEL (misaligned or illegal op) and bus timeout.
//   clk, rst_n          clock / async active-low reset
//   ld_valid, ld_op,    load request from M stage (held until ld_done)
//   ld_addr, flush      flush discards the current load
//   bus_req, bus_addr,  word-aligned read request
//   bus_ack, bus_rdata  read completion
//   ld_busy             combinational stall
//   ld_done, ld_data,   completion pulse, result (held), AdEL, bus error
//   ld_exc, ld_berr
//
// state  | meaning
// S_IDLE | waiting for a load; accepts when ld_valid & ~flush
// S_WAIT | bus_req high, waiting for bus_ack or timeout
// S_DONE | one-cycle ld_done pulse, result/flags valid
module m_dm_load_ctrl
  import m_dm_load_ctrl_pkg::*;
#(
  parameter int unsigned BUS_TO = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  input  logic [2:0]  ld_op,
  input  logic [31:0] ld_addr,
  input  logic        flush,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        ld_busy,
  output logic        ld_done,
  output logic [31:0] ld_data,
  output logic        ld_exc,
  output logic        ld_berr
);

  localparam int unsigned CNT_W = (BUS_TO > 2) ? $clog2(BUS_TO) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(BUS_TO - 1);

  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [1:0]       a_q;
  logic             drop_q;
  logic             accept, bad, ack_xfer, tmo, drop_eff;
  logic [31:0]      ext_data;

  assign accept   = (state_q == S_IDLE) && ld_valid && !flush;
  assign bad      = ld_adel(ld_op, ld_addr[1:0]);
  assign ack_xfer = (state_q == S_WAIT) && bus_req && bus_ack;
  // ack on the terminal-count cycle wins over the timeout
  assign tmo      = (state_q == S_WAIT) && !ack_xfer && (cnt == CNT_TC);
  // a flush arriving on the finishing cycle itself still drops the result
  assign drop_eff = drop_q || flush;

  assign ld_busy  = accept || (state_q == S_WAIT);
  assign ld_done  = (state_q == S_DONE);

  m_load_ext u_ext (
    .op   (op_q),
    .a    (a_q),
    .word (bus_rdata),
    .data (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = bad ? S_DONE : S_WAIT;
      S_WAIT: if (ack_xfer || tmo) state_d = drop_eff ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req  <= 1'b0;
      bus_addr <= '0;
      ld_data  <= '0;
      ld_exc   <= 1'b0;
      ld_berr  <= 1'b0;
      cnt      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (accept) begin
        ld_exc  <= bad;
        ld_berr <= 1'b0;
        drop_q  <= 1'b0;
        if (bad) begin
          ld_data <= '0;
        end else begin
          bus_req  <= 1'b1;
          bus_addr <= {ld_addr[31:2], 2'b00};
          op_q     <= ld_op;
          a_q      <= ld_addr[1:0];
          cnt      <= '0;
        end
      end
      if (state_q == S_WAIT) begin
        if (flush) drop_q <= 1'b1;
        if (ack_xfer) begin
          bus_req <= 1'b0;
          if (!drop_eff) ld_data <= ext_data;
        end else if (tmo) begin
          bus_req <= 1'b0;
          if (!drop_eff) begin
            ld_berr <= 1'b1;
            ld_data <= '0;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_m_dm_load_ctrl.sv
module tb_m_dm_load_ctrl;

  localparam int BUS_TO = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic [2:0]  ld_op;
  logic [31:0] ld_addr;
  logic        flush;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        ld_busy;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        ld_exc;
  logic        ld_berr;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model of the architecturally visible result registers
  logic [31:0] exp_data;
  logic        exp_exc;
  logic        exp_berr;

  always #5 clk = ~clk;

  m_dm_load_ctrl #(.BUS_TO(BUS_TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_valid  (ld_valid),
    .ld_op     (ld_op),
    .ld_addr   (ld_addr),
    .flush     (flush),
    .bus_req   (bus_req),
    .bus_addr  (bus_addr),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .ld_busy   (ld_busy),
    .ld_done   (ld_done),
    .ld_data   (ld_data),
    .ld_exc    (ld_exc),
    .ld_berr   (ld_berr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic bit model_exc(input int op, input logic [31:0] addr);
    int unsigned a;
    a = addr % 4;
    return (op > 4) || (op == 0 && a != 0) || ((op == 1 || op == 2) && (a % 2) != 0);
  endfunction

  function automatic logic [31:0] model_data(input int op, input logic [31:0] addr, input logic [31:0] w);
    int unsigned a, v;
    a = addr % 4;
    if (op == 0) return w;
    if (op == 1 || op == 2) begin
      v = (w >> (16 * (a / 2))) & 32'hFFFF;
      if (op == 1 && v >= 32'h8000) v = v + 32'hFFFF0000;
      return v;
    end
    v = (w >> (8 * a)) & 32'hFF;
    if (op == 3 && v >= 128) v = v + 32'hFFFFFF00;
    return v;
  endfunction

  // n_ack: WAIT cycle (1-based) on which bus_ack is given, 0 = never.
  // fl:    WAIT cycle on which flush is pulsed, 0 = none.
  // Entered and left at posedge+1.
  task automatic do_load(input int op, input logic [31:0] addr, input logic [31:0] rd,
                         input int n_ack, input int fl);
    bit bad, acked, drop;
    int nw;
    logic [31:0] aligned;
    bad     = model_exc(op, addr);
    acked   = !bad && (n_ack >= 1) && (n_ack <= BUS_TO);
    nw      = bad ? 0 : (acked ? n_ack : BUS_TO);
    drop    = (fl >= 1) && (fl <= nw);
    aligned = addr & 32'hFFFF_FFFC;

    ld_valid = 1'b1; ld_op = 3'(op); ld_addr = addr; flush = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    chk("acc_busy", ld_busy, 1);
    chk("acc_req", bus_req, 0);
    chk("acc_done", ld_done, 0);
    exp_exc  = bad;
    exp_berr = 1'b0;
    if (bad) exp_data = 32'h0;

    for (int c = 1; c <= nw; c++) begin
      @(posedge clk); #1;
      bus_ack   = (c == n_ack);
      bus_rdata = (c == n_ack) ? rd : $urandom;
      flush     = (c == fl);
      @(negedge clk);
      chk("wait_req", bus_req, 1);
      chk("wait_addr", bus_addr, aligned);
      chk("wait_busy", ld_busy, 1);
      chk("wait_done", ld_done, 0);
    end

    @(posedge clk); #1;
    bus_ack   = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    flush     = 1'b0;
    if (drop) ld_valid = 1'b0;
    if (!drop && !bad) begin
      exp_berr = !acked;
      exp_data = acked ? model_data(op, addr, rd) : 32'h0;
    end
    @(negedge clk);
    chk("fin_done", ld_done, !drop);
    chk("fin_req", bus_req, 0);
    chk("fin_busy", ld_busy, 0);
    chk("fin_data", ld_data, exp_data);
    chk("fin_exc", ld_exc, exp_exc);
    chk("fin_berr", ld_berr, exp_berr);

    @(posedge clk); #1;
    ld_valid  = 1'b0;
    bus_ack   = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    @(negedge clk);
    chk("idle_done", ld_done, 0);
    chk("idle_req", bus_req, 0);
    chk("idle_busy", ld_busy, 0);
    chk("hold_data", ld_data, exp_data);
    @(posedge clk); #1;
    bus_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; ld_op = '0; ld_addr = '0; flush = 1'b0;
    bus_ack = 1'b0; bus_rdata = '0;
    exp_data = 32'h0; exp_exc = 1'b0; exp_berr = 1'b0;
    #2;
    chk("rst_req", bus_req, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_done", ld_done, 0);
    chk("rst_data", ld_data, 0);
    chk("rst_exc", ld_exc, 0);
    chk("rst_berr", ld_berr, 0);
    chk("rst_busy", ld_busy, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_load(0, 32'h100, 32'hDEADBEEF, 1, 0);
    do_load(3, 32'h103, 32'h80FF1234, 1, 0);
    do_load(4, 32'h103, 32'h80FF1234, 1, 0);
    do_load(1, 32'h102, 32'h80FF1234, 2, 0);
    do_load(0, 32'h102, 32'h12345678, 1, 0);
    do_load(6, 32'h100, 32'h12345678, 1, 0);
    do_load(2, 32'h104, 32'h8001F00D, 5, 0);
    do_load(0, 32'h108, 32'h11111111, 0, 0);
    do_load(0, 32'h10C, 32'hCAFEF00D, BUS_TO, 0);
    do_load(0, 32'h110, 32'h22222222, 3, 2);
    do_load(0, 32'h114, 32'h33333333, 2, 2);
    do_load(1, 32'h118, 32'h44444444, 0, 3);

    // flush in IDLE: no accept
    ld_valid = 1'b1; flush = 1'b1; ld_op = 3'd0; ld_addr = 32'h120;
    @(negedge clk);
    chk("iflush_busy", ld_busy, 0);
    @(posedge clk); #1;
    flush = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    chk("iflush_req", bus_req, 0);
    chk("iflush_done", ld_done, 0);
    @(posedge clk); #1;

    // reset pulse in the middle of WAIT
    ld_valid = 1'b1; ld_op = 3'd0; ld_addr = 32'h200;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst_pre_req", bus_req, 1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_req", bus_req, 0);
    chk("mrst_addr", bus_addr, 0);
    chk("mrst_data", ld_data, 0);
    chk("mrst_berr", ld_berr, 0);
    chk("mrst_busy", ld_busy, 0);
    exp_data = 32'h0; exp_exc = 1'b0; exp_berr = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst_done", ld_done, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      int op, na, fl;
      op = $urandom_range(0, 7);
      na = $urandom_range(0, BUS_TO + 2);
      fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, BUS_TO) : 0;
      do_load(op, $urandom, $urandom, na, fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
